ats21_cmd_sequencer: RTL and testbench

- Front-end controller for the ATS21 timer block.
- Accepts whole 32-bit ATS21 instructions from two independent requesters (client A, client B) through per-client valid/ready queues.
- Serialises each instruction into the ATS21 two-beat 16-bit protocol on req/ctrlA/ctrlB and collects the per-client stat ack/nack.
- Separates same-resource conflicts into different slots so no command is lost to a device-side double-Nack.

---
 rtl/ats21_pkg.sv | 58 +++++
 rtl/ats21_cmd_fifo.sv | 51 +++++
 rtl/ats21_cmd_sequencer.sv | 163 ++++++++++++++++
 tb/tb_ats21_cmd_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ats21_pkg.sv
// rtl/ats21_pkg.sv - ATS21 command fields, opcode/class/state enums and conflict check
package ats21_pkg;

  localparam int CMD_W       = 32;
  localparam int OP_MSB      = 31;
  localparam int OP_LSB      = 29;
  localparam int CLK_KEY_MSB = 28;
  localparam int CLK_KEY_LSB = 25;
  localparam int ALM_KEY_MSB = 28;
  localparam int ALM_KEY_LSB = 24;
  localparam int KEYS_LSB    = 24;

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_SET_CLK = 3'b001,
    OP_EN_CLK  = 3'b010,
    OP_MODE    = 3'b011,
    OP_SET_ALM = 3'b101,
    OP_SET_TMR = 3'b110,
    OP_EN_ALM  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {CLS_CLK, CLS_ALM, CLS_MODE, CLS_NONE} cmd_class_e;

  typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_LO, ST_WAIT} seq_state_e;

  function automatic cmd_class_e cmd_class(input logic [2:0] op);
    cmd_class_e cls;
    case (op)
      OP_SET_CLK, OP_EN_CLK:             cls = CLS_CLK;
      OP_MODE:                           cls = CLS_MODE;
      OP_SET_ALM, OP_SET_TMR, OP_EN_ALM: cls = CLS_ALM;
      default:                           cls = CLS_NONE;
    endcase
    return cls;
  endfunction

  // Arguments are the top byte of each command: opcode plus the widest key.
  function automatic logic conflict(input logic [CMD_W-1:KEYS_LSB] cmd_a,
                                    input logic [CMD_W-1:KEYS_LSB] cmd_b);
    cmd_class_e ca;
    cmd_class_e cb;
    logic       hit;
    ca  = cmd_class(cmd_a[OP_MSB:OP_LSB]);
    cb  = cmd_class(cmd_b[OP_MSB:OP_LSB]);
    hit = 1'b0;
    if (ca == cb) begin
      case (ca)
        CLS_CLK:  hit = (cmd_a[CLK_KEY_MSB:CLK_KEY_LSB] == cmd_b[CLK_KEY_MSB:CLK_KEY_LSB]);
        CLS_ALM:  hit = (cmd_a[ALM_KEY_MSB:ALM_KEY_LSB] == cmd_b[ALM_KEY_MSB:ALM_KEY_LSB]);
        CLS_MODE: hit = 1'b1;
        default:  hit = 1'b0;
      endcase
    end
    return hit;
  endfunction

endpackage

// File: rtl/ats21_cmd_fifo.sv
// rtl/ats21_cmd_fifo.sv - per-client command queue, valid/ready in, pop/empty out
module ats21_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] out_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             do_pop;

  assign in_ready = (count != (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push     = in_valid && in_ready;
  assign do_pop   = pop && !empty;
  assign out_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ats21_cmd_sequencer.sv
// rtl/ats21_cmd_sequencer.sv - two-client ATS21 front end: queues, conflict split, two-beat issue
// Optional Nack re-issue enabled by defining ATS21_SEQ_RETRY_EN.
module ats21_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int STAT_LAT   = 1,
  parameter int MAX_RETRY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [31:0] a_cmd,
  output logic        a_ready,
  output logic        a_rsp_valid,
  output logic        a_rsp_ack,
  input  logic        b_valid,
  input  logic [31:0] b_cmd,
  output logic        b_ready,
  output logic        b_rsp_valid,
  output logic        b_rsp_ack,
  output logic        dev_req,
  output logic [15:0] dev_ctrlA,
  output logic [15:0] dev_ctrlB,
  input  logic [1:0]  dev_stat
);

  import ats21_pkg::*;

  localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int WW = (STAT_LAT > 1) ? $clog2(STAT_LAT) : 1;
`ifdef ATS21_SEQ_RETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRY;
`else
  localparam int RETRY_LIMIT = 0;
`endif
  localparam logic [CW-1:0] TRY_LAST  = CW'(RETRY_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(STAT_LAT - 1);

  seq_state_e  state, state_nxt;
  logic [31:0] a_head, b_head, a_sel, b_sel, a_cur, b_cur;
  logic        a_empty, b_empty, a_pop, b_pop;
  logic        a_have, b_have, a_go, b_go, heads_conflict, start;
  logic        a_iss, b_iss, a_retry, b_retry, rr_b, wait_last;
  logic [CW-1:0] a_tries, b_tries;
  logic [WW-1:0] wait_cnt;

  ats21_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_data(a_cmd), .in_ready(a_ready),
    .pop(a_pop), .out_data(a_head), .empty(a_empty)
  );

  ats21_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_data(b_cmd), .in_ready(b_ready),
    .pop(b_pop), .out_data(b_head), .empty(b_empty)
  );

  // A pending retry takes its side's slot ahead of the FIFO and wins any conflict.
  always_comb begin
    a_sel          = a_retry ? a_cur : a_head;
    b_sel          = b_retry ? b_cur : b_head;
    a_have         = a_retry || !a_empty;
    b_have         = b_retry || !b_empty;
    heads_conflict = a_have && b_have && conflict(a_sel[31:24], b_sel[31:24]);
    a_go           = 1'b0;
    b_go           = 1'b0;
    if (state == ST_IDLE) begin
      if (!heads_conflict) begin
        a_go = a_have;
        b_go = b_have;
      end else if (a_retry) begin
        a_go = 1'b1;
      end else if (b_retry) begin
        b_go = 1'b1;
      end else if (rr_b) begin
        b_go = 1'b1;
      end else begin
        a_go = 1'b1;
      end
    end
    a_pop     = a_go && !a_retry;
    b_pop     = b_go && !b_retry;
    start     = a_go || b_go;
    wait_last = (wait_cnt == WAIT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_HI;
      ST_HI:   state_nxt = ST_LO;
      ST_LO:   state_nxt = ST_WAIT;
      ST_WAIT: if (wait_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    dev_req   = (state == ST_HI) || (state == ST_LO);
    dev_ctrlA = 16'h0000;
    dev_ctrlB = 16'h0000;
    if (state == ST_HI) begin
      if (a_iss) dev_ctrlA = a_cur[31:16];
      if (b_iss) dev_ctrlB = b_cur[31:16];
    end else if (state == ST_LO) begin
      if (a_iss) dev_ctrlA = a_cur[15:0];
      if (b_iss) dev_ctrlB = b_cur[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_cur <= '0;  b_cur <= '0;
      a_iss <= 1'b0; b_iss <= 1'b0;
      a_retry <= 1'b0; b_retry <= 1'b0;
      a_tries <= '0; b_tries <= '0;
      rr_b <= 1'b0;
      wait_cnt <= '0;
      a_rsp_valid <= 1'b0; a_rsp_ack <= 1'b0;
      b_rsp_valid <= 1'b0; b_rsp_ack <= 1'b0;
    end else begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      if (start) begin
        a_iss <= a_go;
        b_iss <= b_go;
        if (a_go) a_cur <= a_sel;
        if (b_go) b_cur <= b_sel;
        if (heads_conflict && !a_retry && !b_retry) rr_b <= ~rr_b;
      end
      if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                  wait_cnt <= '0;
      if ((state == ST_WAIT) && wait_last) begin
        if (a_iss) begin
          if (dev_stat[0] || (a_tries == TRY_LAST)) begin
            a_rsp_valid <= 1'b1;
            a_rsp_ack   <= dev_stat[0];
            a_retry     <= 1'b0;
            a_tries     <= '0;
          end else begin
            a_retry <= 1'b1;
            a_tries <= a_tries + 1'b1;
          end
        end
        if (b_iss) begin
          if (dev_stat[1] || (b_tries == TRY_LAST)) begin
            b_rsp_valid <= 1'b1;
            b_rsp_ack   <= dev_stat[1];
            b_retry     <= 1'b0;
            b_tries     <= '0;
          end else begin
            b_retry <= 1'b1;
            b_tries <= b_tries + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ats21_cmd_sequencer.sv
// tb/tb_ats21_cmd_sequencer.sv - directed self-checking bench for ats21_cmd_sequencer
module tb_ats21_cmd_sequencer;

  logic        clk;
  logic        reset;
  logic        a_valid, b_valid;
  logic [31:0] a_cmd, b_cmd;
  logic        a_ready, b_ready;
  logic        a_rsp_valid, a_rsp_ack, b_rsp_valid, b_rsp_ack;
  logic        dev_req;
  logic [15:0] dev_ctrlA, dev_ctrlB;
  logic [1:0]  dev_stat;

  int errors = 0;
  int checks = 0;

  logic [15:0] hi_a[$];
  logic [15:0] hi_b[$];
  logic        req_d = 1'b0;

`ifdef ATS21_SEQ_RETRY_EN
  localparam int EXP_ISSUES = 3;
`else
  localparam int EXP_ISSUES = 1;
`endif

  ats21_cmd_sequencer dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_cmd(a_cmd), .a_ready(a_ready),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ack(a_rsp_ack),
    .b_valid(b_valid), .b_cmd(b_cmd), .b_ready(b_ready),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ack(b_rsp_ack),
    .dev_req(dev_req), .dev_ctrlA(dev_ctrlA), .dev_ctrlB(dev_ctrlB),
    .dev_stat(dev_stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records the high beat of every slot on both channels.
  always @(negedge clk) begin
    if (dev_req && !req_d) begin
      hi_a.push_back(dev_ctrlA);
      hi_b.push_back(dev_ctrlB);
    end
    req_d = dev_req;
  end

  task automatic enq(input logic va, input logic [31:0] ca, input logic vb, input logic [31:0] cb);
    a_valid = va; a_cmd = ca; b_valid = vb; b_cmd = cb;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dev_req !== 1'b0 || dev_ctrlA !== 16'h0 || dev_ctrlB !== 16'h0) begin
      errors++; $display("FAIL reset_dev: req=%b ctrlA=%h ctrlB=%h expected 0/0000/0000", dev_req, dev_ctrlA, dev_ctrlB);
    end
    checks++;
    if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0 || a_rsp_ack !== 1'b0 || b_rsp_ack !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: a=%b/%b b=%b/%b expected all 0", a_rsp_valid, a_rsp_ack, b_rsp_valid, b_rsp_ack);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    dev_stat = 2'b01;
    enq(1'b1, 32'h2600_0010, 1'b0, 32'h0);
    checks++;
    if (dev_req !== 1'b0) begin errors++; $display("FAIL single_idle: req=%b expected 0", dev_req); end
    @(negedge clk);
    checks++;
    if (dev_req !== 1'b1 || dev_ctrlA !== 16'h2600 || dev_ctrlB !== 16'h0000) begin
      errors++; $display("FAIL single_hi: req=%b A=%h B=%h expected 1/2600/0000", dev_req, dev_ctrlA, dev_ctrlB);
    end
    @(negedge clk);
    checks++;
    if (dev_req !== 1'b1 || dev_ctrlA !== 16'h0010 || dev_ctrlB !== 16'h0000) begin
      errors++; $display("FAIL single_lo: req=%b A=%h B=%h expected 1/0010/0000", dev_req, dev_ctrlA, dev_ctrlB);
    end
    @(negedge clk);
    checks++;
    if (dev_req !== 1'b0 || a_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_wait: req=%b rsp=%b expected 0/0", dev_req, a_rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (a_rsp_valid !== 1'b1 || a_rsp_ack !== 1'b1 || b_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_rsp: a=%b ack=%b b=%b expected 1/1/0", a_rsp_valid, a_rsp_ack, b_rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: rsp=%b expected 0", a_rsp_valid); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_shared;
    dev_stat = 2'b11;
    enq(1'b1, 32'h2600_0010, 1'b1, 32'h2A00_0010);
    @(negedge clk);
    checks++;
    if (dev_ctrlA !== 16'h2600 || dev_ctrlB !== 16'h2A00) begin
      errors++; $display("FAIL shared_hi: A=%h B=%h expected 2600/2a00", dev_ctrlA, dev_ctrlB);
    end
    @(negedge clk);
    checks++;
    if (dev_ctrlA !== 16'h0010 || dev_ctrlB !== 16'h0010) begin
      errors++; $display("FAIL shared_lo: A=%h B=%h expected 0010/0010", dev_ctrlA, dev_ctrlB);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({a_rsp_valid, a_rsp_ack, b_rsp_valid, b_rsp_ack} !== 4'b1111) begin
      errors++; $display("FAIL shared_rsp: got %b expected 1111", {a_rsp_valid, a_rsp_ack, b_rsp_valid, b_rsp_ack});
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_conflict;
    int req_cycles;
    dev_stat = 2'b11;
    hi_a.delete(); hi_b.delete();
    req_cycles = 0;
    enq(1'b1, 32'hA403_0020, 1'b1, 32'hC403_0008);
    @(negedge clk); req_cycles += int'(dev_req);
    checks++;
    if (dev_ctrlA !== 16'hA403 || dev_ctrlB !== 16'h0000) begin
      errors++; $display("FAIL conflict_s1_hi: A=%h B=%h expected a403/0000", dev_ctrlA, dev_ctrlB);
    end
    @(negedge clk); req_cycles += int'(dev_req);
    @(negedge clk); req_cycles += int'(dev_req);
    @(negedge clk); req_cycles += int'(dev_req);
    checks++;
    if (a_rsp_valid !== 1'b1 || b_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL conflict_s1_rsp: a=%b b=%b expected 1/0", a_rsp_valid, b_rsp_valid);
    end
    @(negedge clk); req_cycles += int'(dev_req);
    checks++;
    if (dev_req !== 1'b1 || dev_ctrlA !== 16'h0000 || dev_ctrlB !== 16'hC403) begin
      errors++; $display("FAIL conflict_s2_hi: req=%b A=%h B=%h expected 1/0000/c403", dev_req, dev_ctrlA, dev_ctrlB);
    end
    @(negedge clk); req_cycles += int'(dev_req);
    checks++;
    if (dev_ctrlB !== 16'h0008) begin errors++; $display("FAIL conflict_s2_lo: B=%h expected 0008", dev_ctrlB); end
    @(negedge clk); req_cycles += int'(dev_req);
    @(negedge clk); req_cycles += int'(dev_req);
    checks++;
    if (b_rsp_valid !== 1'b1 || b_rsp_ack !== 1'b1 || a_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL conflict_s2_rsp: b=%b ack=%b a=%b expected 1/1/0", b_rsp_valid, b_rsp_ack, a_rsp_valid);
    end
    repeat (6) begin @(negedge clk); req_cycles += int'(dev_req); end
    checks++;
    if (hi_a.size() != 2 || req_cycles != 4) begin
      errors++; $display("FAIL conflict_slots: slots=%0d req_cycles=%0d expected 2/4", hi_a.size(), req_cycles);
    end
  endtask

  task automatic test_fill;
    logic [31:0] cmds[6];
    logic [6:0]  exp_rdy;
    logic        prev;
    int          sent;
    int          pulses;
    dev_stat = 2'b11;
    hi_a.delete(); hi_b.delete();
    for (int i = 0; i < 6; i++) cmds[i] = {3'b001, 4'(i), 9'd0, 16'h0100 + 16'(i)};
    exp_rdy = 7'b0101111;
    sent = 0;
    pulses = 0;
    a_valid = 1'b1; a_cmd = cmds[0];
    prev = a_ready;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (prev && a_valid) sent++;
      if (a_rsp_valid) pulses++;
      checks++;
      if (a_ready !== exp_rdy[k]) begin
        errors++; $display("FAIL fill_ready_%0d: a_ready=%b expected %b", k + 1, a_ready, exp_rdy[k]);
      end
      prev = a_ready;
      if (sent < 6) a_cmd = cmds[sent];
      else          a_valid = 1'b0;
    end
    checks++;
    if (sent != 6) begin errors++; $display("FAIL fill_accepted: got %0d expected 6", sent); end
    repeat (30) begin @(negedge clk); if (a_rsp_valid) pulses++; end
    checks++;
    if (pulses != 6 || hi_a.size() != 6) begin
      errors++; $display("FAIL fill_drain: rsp=%0d slots=%0d expected 6/6", pulses, hi_a.size());
    end
    for (int i = 0; i < 6 && i < hi_a.size(); i++) begin
      checks++;
      if (hi_a[i] !== cmds[i][31:16]) begin
        errors++; $display("FAIL fill_order_%0d: got %h expected %h", i, hi_a[i], cmds[i][31:16]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int bad_req;
    int bad_rsp;
    dev_stat = 2'b11;
    a_valid = 1'b1; a_cmd = 32'h2600_0010; b_valid = 1'b1; b_cmd = 32'h2A00_0010;
    @(negedge clk);
    a_cmd = 32'h2600_0011; b_cmd = 32'h2A00_0011;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dev_req !== 1'b1 || dev_ctrlA !== 16'h0010) begin
      errors++; $display("FAIL rmid_lo: req=%b A=%h expected 1/0010", dev_req, dev_ctrlA);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (dev_req !== 1'b0) begin errors++; $display("FAIL rmid_async: req=%b expected 0", dev_req); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad_req = 0;
    bad_rsp = 0;
    repeat (12) begin
      @(negedge clk);
      if (dev_req) bad_req++;
      if (a_rsp_valid || b_rsp_valid) bad_rsp++;
    end
    checks++;
    if (bad_req != 0 || bad_rsp != 0) begin
      errors++; $display("FAIL rmid_quiet: req_cycles=%0d rsp_cycles=%0d expected 0/0", bad_req, bad_rsp);
    end
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_ready: a=%b b=%b expected 1/1", a_ready, b_ready);
    end
  endtask

  task automatic test_retry;
    int   pulses;
    logic last_ack;
    dev_stat = 2'b00;
    hi_a.delete(); hi_b.delete();
    pulses = 0;
    last_ack = 1'b1;
    enq(1'b1, 32'h2600_0010, 1'b0, 32'h0);
    repeat (40) begin
      @(negedge clk);
      if (a_rsp_valid) begin pulses++; last_ack = a_rsp_ack; end
    end
    checks++;
    if (pulses != 1 || last_ack !== 1'b0) begin
      errors++; $display("FAIL retry_rsp: pulses=%0d ack=%b expected 1/0", pulses, last_ack);
    end
    checks++;
    if (hi_a.size() != EXP_ISSUES) begin
      errors++; $display("FAIL retry_issues: got %0d expected %0d", hi_a.size(), EXP_ISSUES);
    end
    for (int i = 0; i < hi_a.size(); i++) begin
      checks++;
      if (hi_a[i] !== 16'h2600) begin errors++; $display("FAIL retry_cmd_%0d: got %h expected 2600", i, hi_a[i]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_cmd = 32'h0; b_cmd = 32'h0;
    dev_stat = 2'b00;
    test_reset();
    test_single();
    test_shared();
    test_conflict();
    test_fill();
    test_reset_mid();
    test_retry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
